// File: rtl/expression_solver_pkg.sv
// Shared types and widths for the quadratic expression solver.
package expression_solver_pkg;

   localparam int unsigned DATA_W = 16;
   localparam int unsigned X_W    = 8;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      SQUARE = 3'd1,
      MUL_A  = 3'd2,
      MUL_B  = 3'd3,
      SUM1   = 3'd4,
      SUM2   = 3'd5,
      DONE   = 3'd6
   } state_e;

   typedef enum logic {
      ALU_MUL = 1'b0,
      ALU_ADD = 1'b1
   } alu_op_e;

endpackage

// File: rtl/expression_solver_if.sv
// Request/response bundle between a requester and the expression solver.
interface expression_solver_if;
   import expression_solver_pkg::*;

   logic              start;
   logic [X_W-1:0]    x;
   logic [DATA_W-1:0] a;
   logic [DATA_W-1:0] b;
   logic [DATA_W-1:0] c;
   logic [DATA_W-1:0] result;
   logic              zero;
   logic              overflow;
   logic              completed;

   modport master (output start, x, a, b, c,
                   input  result, zero, overflow, completed);

   modport slave  (input  start, x, a, b, c,
                   output result, zero, overflow, completed);

endinterface

// File: rtl/solver_alu.sv
// Shared arithmetic unit: 16x16 multiply with overflow, 16-bit add with carry.
module solver_alu
   import expression_solver_pkg::*;
(
   input  alu_op_e           op_i,
   input  logic [DATA_W-1:0] a_i,
   input  logic [DATA_W-1:0] b_i,
   output logic [DATA_W-1:0] y_c_o,
   output logic              ovf_c_o
);

   logic [2*DATA_W-1:0] prod;
   logic [DATA_W:0]     sum;

   // Both results are formed every cycle; the op code picks which one is used.
   always_comb begin
      prod = (2*DATA_W)'(a_i) * (2*DATA_W)'(b_i);
      sum  = (DATA_W+1)'(a_i) + (DATA_W+1)'(b_i);
      if (op_i == ALU_MUL) begin
         y_c_o   = prod[DATA_W-1:0];
         ovf_c_o = |prod[2*DATA_W-1:DATA_W];
      end else begin
         y_c_o   = sum[DATA_W-1:0];
         ovf_c_o = sum[DATA_W];
      end
   end

endmodule

// File: rtl/expression_solver.sv
// Sequential evaluator of A*X*X + B*X + C using one shared ALU.
module expression_solver
   import expression_solver_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [X_W-1:0]    X,
   input  logic [DATA_W-1:0] A,
   input  logic [DATA_W-1:0] B,
   input  logic [DATA_W-1:0] C,
   output logic [DATA_W-1:0] result,
   output logic              zero,
   output logic              overflow,
   output logic              completed
);

   state_e            state_q, state_d;
   logic [X_W-1:0]    x_q, x_d;
   logic [DATA_W-1:0] a_q, a_d, b_q, b_d, c_q, c_d;
   logic [DATA_W-1:0] t_q, t_d, p_q, p_d, bx_q, bx_d, s_q, s_d;
   logic              ovf_q, ovf_d;
   logic [DATA_W-1:0] result_q, result_d;
   logic              zero_q, zero_d, overflow_q, overflow_d;
   logic              completed_q, completed_d;

   alu_op_e           alu_op;
   logic [DATA_W-1:0] alu_a, alu_b, alu_y;
   logic              alu_ovf;

   solver_alu u_alu (
      .op_i    (alu_op),
      .a_i     (alu_a),
      .b_i     (alu_b),
      .y_c_o   (alu_y),
      .ovf_c_o (alu_ovf)
   );

   // State, operand, intermediate and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         x_q         <= '0;
         a_q         <= '0;
         b_q         <= '0;
         c_q         <= '0;
         t_q         <= '0;
         p_q         <= '0;
         bx_q        <= '0;
         s_q         <= '0;
         ovf_q       <= 1'b0;
         result_q    <= '0;
         zero_q      <= 1'b0;
         overflow_q  <= 1'b0;
         completed_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         x_q         <= x_d;
         a_q         <= a_d;
         b_q         <= b_d;
         c_q         <= c_d;
         t_q         <= t_d;
         p_q         <= p_d;
         bx_q        <= bx_d;
         s_q         <= s_d;
         ovf_q       <= ovf_d;
         result_q    <= result_d;
         zero_q      <= zero_d;
         overflow_q  <= overflow_d;
         completed_q <= completed_d;
      end
   end

   // Step sequencing: each state issues one ALU operation and stores its result.
   always_comb begin
      state_d     = state_q;
      x_d         = x_q;
      a_d         = a_q;
      b_d         = b_q;
      c_d         = c_q;
      t_d         = t_q;
      p_d         = p_q;
      bx_d        = bx_q;
      s_d         = s_q;
      ovf_d       = ovf_q;
      result_d    = result_q;
      zero_d      = zero_q;
      overflow_d  = overflow_q;
      completed_d = completed_q;
      alu_op      = ALU_MUL;
      alu_a       = '0;
      alu_b       = '0;

      case (state_q)
         IDLE: begin
            if (start) begin
               x_d     = X;
               a_d     = A;
               b_d     = B;
               c_d     = C;
               ovf_d   = 1'b0;
               state_d = SQUARE;
            end
         end
         SQUARE: begin
            // 255*255 fits in 16 bits, so no overflow is possible here.
            alu_a   = DATA_W'(x_q);
            alu_b   = DATA_W'(x_q);
            t_d     = alu_y;
            state_d = MUL_A;
         end
         MUL_A: begin
            alu_a   = a_q;
            alu_b   = t_q;
            p_d     = alu_y;
            ovf_d   = ovf_q | alu_ovf;
            state_d = MUL_B;
         end
         MUL_B: begin
            alu_a   = b_q;
            alu_b   = DATA_W'(x_q);
            bx_d    = alu_y;
            ovf_d   = ovf_q | alu_ovf;
            state_d = SUM1;
         end
         SUM1: begin
            alu_op  = ALU_ADD;
            alu_a   = p_q;
            alu_b   = bx_q;
            s_d     = alu_y;
            ovf_d   = ovf_q | alu_ovf;
            state_d = SUM2;
         end
         SUM2: begin
            alu_op      = ALU_ADD;
            alu_a       = s_q;
            alu_b       = c_q;
            ovf_d       = ovf_q | alu_ovf;
            result_d    = alu_y;
            zero_d      = (alu_y == '0);
            overflow_d  = ovf_q | alu_ovf;
            completed_d = 1'b1;
            state_d     = DONE;
         end
         DONE: begin
            // Holding here while start stays high keeps one request to one run.
            if (!start) begin
               completed_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign result    = result_q;
   assign zero      = zero_q;
   assign overflow  = overflow_q;
   assign completed = completed_q;

endmodule

// File: tb/tb_expression_solver.sv
// Directed bench for expression_solver with a cycle-level reference model.
module tb_expression_solver;
   import expression_solver_pkg::*;

   logic clk = 1'b0;
   logic rst;

   expression_solver_if bus ();

   always #5 clk = ~clk;

   expression_solver dut (
      .clk       (clk),
      .rst       (rst),
      .start     (bus.start),
      .X         (bus.x),
      .A         (bus.a),
      .B         (bus.b),
      .C         (bus.c),
      .result    (bus.result),
      .zero      (bus.zero),
      .overflow  (bus.overflow),
      .completed (bus.completed)
   );

   int vectors     = 0;
   int miscompares = 0;

   task automatic check(input string name, input longint got, input longint exp);
      vectors++;
      if (got != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
      end
   endtask

   // Reference model: a launch countdown and the full-precision polynomial.
   int          phase       = 0;
   bit          model_valid = 1'b0;
   longint      m_x, m_a, m_b, m_c, full;
   logic [15:0] exp_result;
   bit          exp_zero, exp_ovf, exp_done;

   always @(posedge clk) begin
      if (rst) begin
         phase = 0; exp_result = 16'd0; exp_zero = 0; exp_ovf = 0; exp_done = 0;
         model_valid = 1'b1;
      end else if (phase == 0) begin
         if (bus.start) begin
            m_x = longint'(bus.x); m_a = longint'(bus.a);
            m_b = longint'(bus.b); m_c = longint'(bus.c);
            phase = 1;
         end
      end else if (phase < 5) begin
         phase++;
      end else if (phase == 5) begin
         full       = m_a * m_x * m_x + m_b * m_x + m_c;
         exp_result = full[15:0];
         exp_zero   = (full[15:0] == 16'd0);
         exp_ovf    = (full > 65535);
         exp_done   = 1'b1;
         phase      = 6;
      end else if (!bus.start) begin
         exp_done = 1'b0;
         phase    = 0;
      end
   end

   // Every cycle after reset is seen, outputs must match the model.
   always @(negedge clk) begin
      if (model_valid) begin
         check("cyc_completed", longint'(bus.completed), longint'(exp_done));
         check("cyc_result",    longint'(bus.result),    longint'(exp_result));
         check("cyc_zero",      longint'(bus.zero),      longint'(exp_zero));
         check("cyc_overflow",  longint'(bus.overflow),  longint'(exp_ovf));
      end
   end

   task automatic wait_done(input string tag, input int already, output int n);
      n = already;
      while (!bus.completed && n < 20) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_latency"}, longint'(n), 6);
   endtask

   task automatic run_case(input string tag,
                           input logic [7:0] x, input logic [15:0] a,
                           input logic [15:0] b, input logic [15:0] c,
                           input longint er, input longint ez, input longint eo,
                           input int hold, input bit pulse);
      int n;
      bus.x = x; bus.a = a; bus.b = b; bus.c = c; bus.start = 1'b1;
      @(negedge clk);
      if (pulse) begin
         bus.start = 1'b0;
         bus.x = 8'd200; bus.a = 16'd500; bus.b = 16'd7; bus.c = 16'd9;
      end
      wait_done(tag, 1, n);
      check({tag, "_result"},   longint'(bus.result),   er);
      check({tag, "_zero"},     longint'(bus.zero),     ez);
      check({tag, "_overflow"}, longint'(bus.overflow), eo);
      check({tag, "_model"},    longint'(exp_result),   er);
      if (hold > 0) begin
         bus.x = 8'd3; bus.a = 16'd4; bus.b = 16'd5; bus.c = 16'd6;
         repeat (hold) @(negedge clk);
         check({tag, "_hold_completed"}, longint'(bus.completed), 1);
         check({tag, "_hold_result"},    longint'(bus.result),    er);
      end
      bus.start = 1'b0;
      @(negedge clk);
      check({tag, "_drop_completed"}, longint'(bus.completed), 0);
      check({tag, "_kept_result"},    longint'(bus.result),    er);
      check({tag, "_kept_overflow"},  longint'(bus.overflow),  eo);
      @(negedge clk);
   endtask

   initial begin
      int n;
      rst = 1'b1;
      bus.start = 1'b0; bus.x = '0; bus.a = '0; bus.b = '0; bus.c = '0;
      repeat (2) @(negedge clk);
      check("rst_result",    longint'(bus.result),    0);
      check("rst_completed", longint'(bus.completed), 0);
      rst = 1'b0;

      run_case("basic",  8'd15,  16'd96,    16'd3,     16'd1, 21646, 0, 0, 5, 1'b0);
      run_case("allzero", 8'd0,  16'd0,     16'd0,     16'd0, 0,     1, 0, 0, 1'b0);
      run_case("bigmul", 8'd255, 16'd65535, 16'd0,     16'd0, 511,   0, 1, 0, 1'b0);
      run_case("wrap0",  8'd1,   16'd0,     16'd65535, 16'd1, 0,     1, 1, 0, 1'b0);

      // Reset in the middle of a run, then relaunch from the still-high start.
      bus.x = 8'd7; bus.a = 16'd5; bus.b = 16'd11; bus.c = 16'd100; bus.start = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("midrst_result",    longint'(bus.result),    0);
      check("midrst_zero",      longint'(bus.zero),      0);
      check("midrst_overflow",  longint'(bus.overflow),  0);
      check("midrst_completed", longint'(bus.completed), 0);
      rst = 1'b0;
      wait_done("restart", 0, n);
      check("restart_result", longint'(bus.result), 422);
      bus.start = 1'b0;
      repeat (2) @(negedge clk);

      run_case("latched", 8'd10, 16'd2, 16'd3, 16'd4, 234, 0, 0, 0, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/expression_solver.md
EXPRESSION_SOLVER -- requirements
Module: expression_solver

Interface
- REQ-001 SHALL have one clock and a synchronous, active-high reset; the clock port is named clk and the reset port is named rst.
- REQ-002 clk  input  1  rising-edge clock for all state.
- REQ-003 rst  input  1  synchronous active-high reset, sampled on rising clk.
- REQ-004 start  input  1  level request; sampled only in IDLE.
- REQ-005 X  input  8  unsigned variable x.
- REQ-006 A  input  16  unsigned quadratic coefficient.
- REQ-007 B  input  16  unsigned linear coefficient.
- REQ-008 C  input  16  unsigned constant term.
- REQ-009 result  output  16  registered low 16 bits of A*X*X + B*X + C.
- REQ-010 zero  output  1  registered; 1 when result == 0 at completion.
- REQ-011 overflow  output  1  registered; 1 when the true value exceeds 65535.
- REQ-012 completed  output  1  registered; high while in DONE.
- REQ-013 Port order SHALL be: clk, rst, start, X, A, B, C, result, zero, overflow, completed.

Function
- REQ-014 SHALL use FSM states IDLE, SQUARE, MUL_A, MUL_B, SUM1, SUM2, DONE, each one cycle except IDLE and DONE.
- REQ-015 IDLE with start=1 at a rising edge SHALL latch X, A, B and C into internal registers, clear the internal overflow flag, and go to SQUARE; with start=0 it SHALL stay in IDLE.
- REQ-016 SQUARE: t = X*X (16 bits; the maximum value 65025 cannot overflow). Then go to MUL_A.
- REQ-017 MUL_A: p = low16(A*t); set the overflow flag if the upper 16 bits of the 32-bit product are non-zero.
- REQ-018 MUL_B: q = low16(B*X); set the overflow flag if the product exceeds 65535.
- REQ-019 SUM1: s = low16(p+q); set the overflow flag on carry out.
- REQ-020 SUM2: r = low16(s+C); set the overflow flag on carry out.
- REQ-021 Overflow SHALL be sticky across all steps of one computation.
- REQ-022 Entry to DONE SHALL load result=r, zero=(r==0), overflow=flag, and completed=1.
- REQ-023 Latency: completed SHALL rise on the 6th rising edge after, and including, the edge that samples start in IDLE.
- REQ-024 DONE SHALL hold all outputs while start=1.
- REQ-025 DONE with start=0 SHALL return to IDLE and drop completed; result, zero and overflow SHALL keep their values until the next completion or reset.
- REQ-026 A continuously high start SHALL produce exactly one computation; a new computation requires start to fall and then rise again.
- REQ-027 Input changes after the start edge SHALL NOT affect the computation in progress.
- REQ-028 zero SHALL be judged on the truncated 16-bit result, so a wrapped result of 0 gives zero=1 and overflow=1.

Reset
- REQ-029 rst=1 SHALL force state to IDLE and clear result, zero, overflow, completed, all operand registers and all intermediate registers, in any state.
- REQ-030 Reset SHALL take priority over start; a computation interrupted by reset is discarded.
- REQ-031 After rst falls, start still high SHALL launch a new computation on the next edge.

Structure
- REQ-032 A shared package SHALL hold the state enum, the data width constant (16) and the X width constant (8).
- REQ-033 A sub-module solver_alu SHALL provide a 16x16 multiply with an overflow flag and a 16-bit add with carry, shared by all steps and selected by an op code.

Verification
- REQ-034 X=15, A=96, B=3, C=1, start held high -> after 6 edges result=21646, zero=0, overflow=0, completed=1; outputs stay stable while start remains high.
- REQ-035 X=0, A=0, B=0, C=0 -> result=0, zero=1, overflow=0.
- REQ-036 X=255, A=65535, B=0, C=0 -> overflow=1 and result=low16(65535*65025).
- REQ-037 X=1, A=0, B=65535, C=1 -> result=0, zero=1, overflow=1.
- REQ-038 Assert rst at cycle 3 of a computation -> all outputs are 0 on the next edge; after rst falls with start high, the computation restarts and completes 6 edges later with the correct value.
- REQ-039 Pulse start, then change X, A, B and C during the computation -> result matches the operands latched at the start edge.
